cache_2way_wb_ctrl: RTL and testbench
=====================================

Name: cache_2way_wb_ctrl

Overview:
Parametrised 2-way set-associative, write-back, write-allocate cache controller with one word per line and per-set LRU. It is the successor of the fixed 5-bit-address, 3-bit-data cache. It sits between the CPU-side request port and main memory. Both sides use explicit valid/ready handshakes, and it keeps saturating hit/miss statistics counters.

Parameters:
DATA_W, 8, data word width in bits.
IDX_W, 2, set index bits; number of sets = 2**IDX_W.
TAG_W, 3, tag bits; ADDR_W = TAG_W+IDX_W (no offset field).
CNT_W, 16, width of the hit/miss statistics counters.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
cpu_req  in  1  CPU request valid; sampled only in IDLE.
cpu_wren  in  1  1 = write, 0 = read.
cpu_addr  in  ADDR_W  tag = [ADDR_W-1:IDX_W], index = [IDX_W-1:0].
cpu_wdata  in  DATA_W  write data.
cpu_ready  out  1  one-cycle completion pulse.
cpu_rdata  out  DATA_W  read data; valid while cpu_ready=1, held afterwards.
hit  out  1  hit flag of the completing access; valid with cpu_ready.
writeback  out  1  high while in WRITEBACK.
mem_req  out  1  memory request; held until acked.
mem_we  out  1  1 = memory write (writeback), 0 = read (fill).
mem_addr  out  ADDR_W  memory word address.
mem_wdata  out  DATA_W  writeback data.
mem_rdata  in  DATA_W  fill data; valid in the mem_ack cycle.
mem_ack  in  1  memory completion; ignored while mem_req=0.
hit_count  out  CNT_W  number of completed hits; saturates at all-ones.
miss_count  out  CNT_W  number of completed misses; saturates at all-ones.

Behaviour:
- Storage per set and way: valid, dirty, tag, data. One LRU bit per set, where lru=w names the victim way.
- Reset (asynchronous): state=IDLE. All valid, dirty and lru bits = 0. All outputs and counters = 0. Data and tag arrays are not cleared.
- Reset mid-transaction: mem_req drops immediately and the transaction is abandoned. No cache state survives.
- FSM states: IDLE, WRITEBACK, FILL, RESPOND.
- IDLE:
  - On cpu_req=1, latch addr, wren and wdata, then perform the tag lookup in the same cycle.
  - Hit in way w: read returns data; write updates data and sets dirty=1. Set lru=~w, go to RESPOND.
  - Miss, victim choice: first invalid way (way0 preferred), else way lru.
  - Miss with victim valid and dirty: go to WRITEBACK.
  - Miss otherwise, read: go to FILL.
  - Miss otherwise, write: install tag and wdata, set valid=1, dirty=1, lru=~victim, go to RESPOND. No fill is needed because the whole line is overwritten.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data, all held stable.
  - On mem_ack: clear the victim's dirty bit. Read goes to FILL. Write installs as described above and goes to RESPOND.
- FILL:
  - mem_req=1, mem_we=0, mem_addr=latched addr.
  - On mem_ack: install mem_rdata, tag, valid=1, dirty=0, lru=~victim, go to RESPOND.
- RESPOND:
  - cpu_ready=1 for exactly one cycle, with cpu_rdata = line data and hit = lookup result.
  - Increment the matching counter; saturate, never wrap.
  - Return to IDLE.
- Latency: hit completes one cycle after acceptance. Misses add one cycle per memory transaction beyond the ack cycle.
- mem_req deasserts in the cycle after mem_ack is sampled.
- Back-to-back: a new cpu_req is accepted in the IDLE cycle following RESPOND. Requests outside IDLE are ignored and not queued.
- Same-set consecutive accesses observe the prior update.
- mem_ack held high across states: each state consumes only the ack it sees while its own mem_req=1.

Test Plan:
- Reset, then read 0x05 with mem_rdata=0x3C acked after 2 cycles -> FILL addr 0x05, cpu_ready with hit=0, rdata=0x3C. Re-read 0x05 -> ready 1 cycle later, hit=1, rdata=0x3C, hit_count=1, miss_count=1.
- Write 0x01=0xAA, then 0x05=0xBB (same set, both ways filled), then read 0x01 -> hit, rdata=0xAA. Way holding 0x05 becomes LRU.
- Continue the previous scenario: read 0x09 (set 1 full, both dirty) -> WRITEBACK mem_addr=0x05, mem_wdata=0xBB, writeback=1, then FILL addr 0x09. Subsequent read 0x01 still hits.
- Write miss to a clean victim -> no mem_req at all, ready 1 cycle after accept, hit=0, line dirty. A later eviction of that line writes back the written value.
- Assert reset_n=0 during FILL with mem_req=1 -> mem_req=0 immediately. After release, re-reading the previously cached address misses.
- Force hit_count to all-ones via a long hit stream -> stays at all-ones, miss_count unaffected.

Source files
------------

// File: rtl/cache_2way_wb_ctrl.sv
// cache_2way_wb_ctrl
//   2-way set-associative, write-back, write-allocate cache controller with
//   one word per line and one LRU bit per set (lru = victim way).
//
// Ports
//   clock, reset_n        : clock, asynchronous active-low reset
//   cpu_req/cpu_wren      : CPU request valid (sampled in IDLE), write select
//   cpu_addr/cpu_wdata    : CPU address {tag,index} and write data
//   cpu_ready/cpu_rdata   : one-cycle completion pulse, read data (held)
//   hit                   : hit flag of the completing access
//   writeback             : high while a dirty victim is written back
//   mem_req/mem_we        : memory request (held until acked), write select
//   mem_addr/mem_wdata    : memory word address, writeback data
//   mem_rdata/mem_ack     : fill data, memory completion
//   hit_count/miss_count  : saturating statistics counters
module cache_2way_wb_ctrl #(
   parameter int DATA_W = 8,
   parameter int IDX_W  = 2,
   parameter int TAG_W  = 3,
   parameter int CNT_W  = 16
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    cpu_req,
   input  logic                    cpu_wren,
   input  logic [TAG_W+IDX_W-1:0]  cpu_addr,
   input  logic [DATA_W-1:0]       cpu_wdata,
   output logic                    cpu_ready,
   output logic [DATA_W-1:0]       cpu_rdata,
   output logic                    hit,
   output logic                    writeback,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [TAG_W+IDX_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   input  logic [DATA_W-1:0]       mem_rdata,
   input  logic                    mem_ack,
   output logic [CNT_W-1:0]        hit_count,
   output logic [CNT_W-1:0]        miss_count
);

   localparam int ADDR_W = TAG_W + IDX_W;
   localparam int SETS   = 2 ** IDX_W;

   typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FILL, S_RESPOND} state_t;

   state_t state, state_nx;

   // line storage
   logic [1:0]        valid_q [SETS];
   logic [1:0]        dirty_q [SETS];
   logic [SETS-1:0]   lru_q;
   logic [TAG_W-1:0]  tag_q   [SETS][2];
   logic [DATA_W-1:0] data_q  [SETS][2];

   // latched request
   logic [ADDR_W-1:0] r_addr;
   logic              r_wren;
   logic [DATA_W-1:0] r_wdata;
   logic              r_way;
   logic              hit_q;
   logic [DATA_W-1:0] rdata_q;
   logic              gap_q;

   // lookup on the live CPU address (used only in IDLE)
   logic [IDX_W-1:0]  lk_idx;
   logic [TAG_W-1:0]  lk_tag;
   logic              lk_hit0, lk_hit1, lk_hit, lk_way, lk_vic, lk_vic_dirty;
   logic [IDX_W-1:0]  r_idx;
   logic [TAG_W-1:0]  r_tag;
   logic              ack_eff;

   // array write controls
   logic              arr_we;
   logic [IDX_W-1:0]  arr_idx;
   logic              arr_way;
   logic [TAG_W-1:0]  arr_tag;
   logic [DATA_W-1:0] arr_data;
   logic              arr_dirty;
   logic              clr_we;
   logic              lru_we;
   logic              lru_val;

   always_comb begin
      lk_idx       = cpu_addr[IDX_W-1:0];
      lk_tag       = cpu_addr[ADDR_W-1:IDX_W];
      lk_hit0      = valid_q[lk_idx][0] && (tag_q[lk_idx][0] == lk_tag);
      lk_hit1      = valid_q[lk_idx][1] && (tag_q[lk_idx][1] == lk_tag);
      lk_hit       = lk_hit0 || lk_hit1;
      lk_way       = lk_hit0 ? 1'b0 : 1'b1;
      if (!valid_q[lk_idx][0])      lk_vic = 1'b0;
      else if (!valid_q[lk_idx][1]) lk_vic = 1'b1;
      else                          lk_vic = lru_q[lk_idx];
      lk_vic_dirty = valid_q[lk_idx][lk_vic] && dirty_q[lk_idx][lk_vic];
      r_idx        = r_addr[IDX_W-1:0];
      r_tag        = r_addr[ADDR_W-1:IDX_W];
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:
            if (cpu_req) begin
               if (lk_hit)            state_nx = S_RESPOND;
               else if (lk_vic_dirty) state_nx = S_WRITEBACK;
               else if (cpu_wren)     state_nx = S_RESPOND;
               else                   state_nx = S_FILL;
            end
         S_WRITEBACK:
            if (ack_eff) state_nx = r_wren ? S_RESPOND : S_FILL;
         S_FILL:
            if (ack_eff) state_nx = S_RESPOND;
         S_RESPOND:
            state_nx = S_IDLE;
         default:
            state_nx = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // gap_q holds mem_req low for the first FILL cycle after a writeback ack,
   // so an ack held high across the two transactions is not consumed twice.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      writeback = 1'b0;
      cpu_ready = 1'b0;
      case (state)
         S_WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {tag_q[r_idx][r_way], r_idx};
            mem_wdata = data_q[r_idx][r_way];
            writeback = 1'b1;
         end
         S_FILL: begin
            mem_req  = !gap_q;
            mem_addr = r_addr;
         end
         S_RESPOND: cpu_ready = 1'b1;
         default: ;
      endcase
      ack_eff = mem_ack && mem_req;
   end

   assign cpu_rdata = rdata_q;
   assign hit       = hit_q;

   // ---------------- array update controls ----------------
   always_comb begin
      arr_we    = 1'b0;
      arr_idx   = r_idx;
      arr_way   = r_way;
      arr_tag   = r_tag;
      arr_data  = r_wdata;
      arr_dirty = 1'b1;
      clr_we    = 1'b0;
      lru_we    = 1'b0;
      lru_val   = ~r_way;
      case (state)
         S_IDLE:
            if (cpu_req) begin
               arr_idx  = lk_idx;
               arr_tag  = lk_tag;
               arr_data = cpu_wdata;
               if (lk_hit) begin
                  arr_way = lk_way;
                  arr_we  = cpu_wren;
                  lru_we  = 1'b1;
                  lru_val = ~lk_way;
               end else if (!lk_vic_dirty && cpu_wren) begin
                  arr_way = lk_vic;
                  arr_we  = 1'b1;
                  lru_we  = 1'b1;
                  lru_val = ~lk_vic;
               end
            end
         S_WRITEBACK:
            if (ack_eff) begin
               clr_we = 1'b1;
               arr_we = r_wren;
               lru_we = r_wren;
            end
         S_FILL:
            if (ack_eff) begin
               arr_we    = 1'b1;
               arr_data  = mem_rdata;
               arr_dirty = 1'b0;
               lru_we    = 1'b1;
            end
         default: ;
      endcase
   end

   // ---------------- control state and counters ----------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_addr     <= '0;
         r_wren     <= 1'b0;
         r_wdata    <= '0;
         r_way      <= 1'b0;
         hit_q      <= 1'b0;
         rdata_q    <= '0;
         gap_q      <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
         lru_q      <= '0;
         for (int unsigned s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
      end else begin
         gap_q <= (state == S_WRITEBACK) && ack_eff && !r_wren;
         if (state == S_IDLE && cpu_req) begin
            r_addr  <= cpu_addr;
            r_wren  <= cpu_wren;
            r_wdata <= cpu_wdata;
            r_way   <= lk_hit ? lk_way : lk_vic;
            hit_q   <= lk_hit;
         end
         if (state != S_RESPOND && state_nx == S_RESPOND)
            rdata_q <= arr_we ? arr_data : data_q[lk_idx][lk_way];
         if (clr_we)
            dirty_q[r_idx][r_way] <= 1'b0;
         if (arr_we) begin
            valid_q[arr_idx][arr_way] <= 1'b1;
            dirty_q[arr_idx][arr_way] <= arr_dirty;
         end
         if (lru_we)
            lru_q[arr_idx] <= lru_val;
         if (state == S_RESPOND) begin
            if (hit_q) begin
               if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            end else begin
               if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            end
         end
      end
   end

   // tag and data arrays are not reset
   always_ff @(posedge clock) begin
      if (arr_we) begin
         tag_q[arr_idx][arr_way]  <= arr_tag;
         data_q[arr_idx][arr_way] <= arr_data;
      end
   end

endmodule

// File: tb/tb_cache_2way_wb_ctrl.sv
// Testbench for cache_2way_wb_ctrl: CPU responses and memory transactions
// are checked against expectation queues filled when each request is issued.
module tb_cache_2way_wb_ctrl;

   localparam int DATA_W = 8;
   localparam int IDX_W  = 2;
   localparam int TAG_W  = 3;
   localparam int CNT_W  = 4;
   localparam int ADDR_W = TAG_W + IDX_W;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              cpu_req, cpu_wren;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ready;
   logic [DATA_W-1:0] cpu_rdata;
   logic              hit, writeback;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic [CNT_W-1:0]  hit_count, miss_count;

   cache_2way_wb_ctrl #(
      .DATA_W(DATA_W), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .hit(hit), .writeback(writeback),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clock = ~clock;

   typedef struct { logic [DATA_W-1:0] rdata; logic hit; } cpu_exp_t;
   typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } mem_exp_t;

   cpu_exp_t cpu_q[$];
   mem_exp_t mem_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int ack_dly  = 2;
   logic [DATA_W-1:0] fill_data = '0;
   int req_cycles = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // memory responder: ack after ack_dly cycles of mem_req, for one cycle
   initial begin
      int mcount;
      mem_exp_t e;
      mcount    = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clock);
         if (mem_req) req_cycles++;
         if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (mem_req && reset_n) begin
            mcount++;
            if (mcount >= ack_dly) begin
               mcount    = 0;
               mem_ack   = 1'b1;
               mem_rdata = fill_data;
               if (mem_q.size() == 0) chk("mem_unexp", 32'(1), 32'(0));
               else begin
                  e = mem_q.pop_front();
                  chk("mem_we", 32'(mem_we), 32'(e.we));
                  chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                  if (e.we) begin
                     chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
                     chk("wb_flag", 32'(writeback), 32'(1));
                  end else begin
                     chk("fill_flag", 32'(writeback), 32'(0));
                  end
               end
            end
         end else begin
            mcount = 0;
         end
      end
   end

   // CPU response monitor
   initial begin
      cpu_exp_t c;
      forever begin
         @(negedge clock);
         if (cpu_ready) begin
            if (cpu_q.size() == 0) chk("cpu_unexp", 32'(1), 32'(0));
            else begin
               c = cpu_q.pop_front();
               chk("rdata", 32'(cpu_rdata), 32'(c.rdata));
               chk("hit", 32'(hit), 32'(c.hit));
            end
         end
      end
   end

   task automatic push_mem(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      mem_exp_t e;
      e.we = we; e.addr = a; e.wdata = d;
      mem_q.push_back(e);
   endtask

   task automatic access(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                         input logic [DATA_W-1:0] er, input logic eh, output int lat);
      cpu_exp_t c;
      c.rdata = er; c.hit = eh;
      cpu_q.push_back(c);
      @(negedge clock);
      cpu_req = 1'b1; cpu_wren = wr; cpu_addr = a; cpu_wdata = wd;
      @(negedge clock);
      cpu_req = 1'b0;
      lat = 1;
      while (!cpu_ready && lat < 60) begin
         @(negedge clock);
         lat++;
      end
      if (!cpu_ready) chk("timeout", 32'(0), 32'(1));
   endtask

   task automatic counts(input int eh, input int em);
      @(negedge clock);
      chk("hit_count", 32'(hit_count), 32'(eh));
      chk("miss_count", 32'(miss_count), 32'(em));
   endtask

   initial begin
      int lat, rc;
      reset_n = 1'b0; cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (2) @(negedge clock);
      chk("rst_ready", 32'(cpu_ready), 32'(0));
      chk("rst_mem_req", 32'(mem_req), 32'(0));
      chk("rst_wb", 32'(writeback), 32'(0));
      chk("rst_hit", 32'(hit), 32'(0));
      chk("rst_rdata", 32'(cpu_rdata), 32'(0));
      chk("rst_hitcnt", 32'(hit_count), 32'(0));
      chk("rst_misscnt", 32'(miss_count), 32'(0));
      reset_n = 1'b1;

      // read miss with fill, then hit
      fill_data = 8'h3C;
      push_mem(1'b0, 5'h05, '0);
      access(1'b0, 5'h05, '0, 8'h3C, 1'b0, lat);
      access(1'b0, 5'h05, '0, 8'h3C, 1'b1, lat);
      chk("lat_hit", 32'(lat), 32'(1));
      counts(1, 1);

      // write miss into invalid way: no memory traffic
      rc = req_cycles;
      access(1'b1, 5'h01, 8'hAA, 8'hAA, 1'b0, lat);
      chk("lat_wmiss", 32'(lat), 32'(1));
      chk("wmiss_nomem", 32'(req_cycles), 32'(rc));
      access(1'b1, 5'h05, 8'hBB, 8'hBB, 1'b1, lat);
      access(1'b0, 5'h01, '0, 8'hAA, 1'b1, lat);

      // dirty victim (0x05) written back, then fill 0x09
      fill_data = 8'h5A;
      push_mem(1'b1, 5'h05, 8'hBB);
      push_mem(1'b0, 5'h09, '0);
      access(1'b0, 5'h09, '0, 8'h5A, 1'b0, lat);
      access(1'b0, 5'h01, '0, 8'hAA, 1'b1, lat);
      counts(4, 3);

      // write miss to clean victim (0x09), later evicted with its written value
      rc = req_cycles;
      access(1'b1, 5'h0D, 8'h77, 8'h77, 1'b0, lat);
      chk("lat_wmiss2", 32'(lat), 32'(1));
      chk("wmiss2_nomem", 32'(req_cycles), 32'(rc));
      fill_data = 8'h11;
      push_mem(1'b1, 5'h01, 8'hAA);
      push_mem(1'b0, 5'h11, '0);
      access(1'b0, 5'h11, '0, 8'h11, 1'b0, lat);
      fill_data = 8'h15;
      push_mem(1'b1, 5'h0D, 8'h77);
      push_mem(1'b0, 5'h15, '0);
      access(1'b0, 5'h15, '0, 8'h15, 1'b0, lat);
      access(1'b0, 5'h15, '0, 8'h15, 1'b1, lat);
      counts(5, 6);

      // reset while FILL is outstanding
      ack_dly = 20;
      @(negedge clock);
      cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 5'h02;
      @(negedge clock);
      cpu_req = 1'b0;
      repeat (2) @(negedge clock);
      chk("fill_req", 32'(mem_req), 32'(1));
      reset_n = 1'b0;
      #1;
      chk("rst_abort_req", 32'(mem_req), 32'(0));
      chk("rst_abort_rdy", 32'(cpu_ready), 32'(0));
      @(negedge clock);
      reset_n = 1'b1;
      ack_dly = 2;
      counts(0, 0);

      // previously cached line must miss after reset
      fill_data = 8'h99;
      push_mem(1'b0, 5'h15, '0);
      access(1'b0, 5'h15, '0, 8'h99, 1'b0, lat);

      // saturate hit counter
      for (int i = 0; i < 20; i++)
         access(1'b0, 5'h15, '0, 8'h99, 1'b1, lat);
      counts(15, 1);

      repeat (3) @(negedge clock);
      chk("cpu_q_left", 32'(cpu_q.size()), 32'(0));
      chk("mem_q_left", 32'(mem_q.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
